flow_qtab: RTL
==============

# flow_qtab

Quantization-table lookup stage placed directly upstream of the flow multiplier in the JPEG flow pipeline. It takes the coefficient stream (N lanes of 16-bit signed data plus sob/eob/sof framing), tracks each coefficient's position inside its 64-coefficient block, and attaches the matching 10-bit unsigned multiplier from a host-loadable table. The output pairs data and multiplier lane-for-lane, ready for the multiplier input.

## Interface

Parameters:
- N, 2: lanes per beat; power of two, 1..8; coefficients per beat.
- Q_NUM, 2: number of stored tables (e.g. luma/chroma); ≥1.

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  pipeline enable; low freezes the stream pipeline and beat counter.
- wr_en  in  1  table write strobe; independent of en.
- wr_tab  in  $clog2(Q_NUM) (min 1)  target table.
- wr_addr  in  6  coefficient index 0..63 within table.
- wr_data  in  10  unsigned multiplier value.
- in_valid  in  1  beat valid.
- in_data  in  N×16 signed  coefficients.
- in_tab  in  $clog2(Q_NUM) (min 1)  table select; sampled on sob beat only.
- in_eob / in_sob / in_sof  in  1 each  end/start of block, start of frame.
- out_valid  out  1  beat valid.
- out_data  out  N×16 signed  delayed in_data.
- out_mult  out  N×10 unsigned  multipliers for out_data lanes.
- out_eob / out_sob / out_sof  out  1 each  delayed framing.
- out_err  out  1  framing error pulse (see Configuration).

## Operation

- Storage: Q_NUM×(64/N) words, each N×10 bits; coefficient index k maps to word k/N, lane k%N. Write sets one lane of word (wr_tab, wr_addr/N) when wr_en=1, via per-lane write enables. Contents not reset.
- Beat counter cnt, width log2(64/N), reset 0. Block table register tab_q, reset 0.
- On en=1 and in_valid=1: if in_sob, read address word 0, tab_q←in_tab, cnt←1; else address word cnt using tab_q, cnt←cnt+1 (natural wrap at 64/N). If in_eob, cnt←0 (overrides increment). sob and eob on same beat (N=64 impossible; treat as sob then eob): read word 0, cnt←0.
- in_valid=0 beats pass through as invalid; cnt and tab_q unchanged; no read required.
- Read/write same word same cycle: read returns old value (read-before-write); new value visible from next read.
- out_mult lane i = table[tab][word][i]; out_data unchanged.

## Timing

- Latency 2 cycles (en=1) from in_* to out_*, all outputs aligned: stage 1 registers data/framing/address, stage 2 registers RAM read data and delayed data/framing.
- en=0: both stages and cnt hold; RAM read port holds output (read enable = en).
- All outputs reset to 0; after reset deassertion first valid output no earlier than 2 enabled cycles after first in_valid.
- Reset mid-block: pipeline flushed, cnt=0, tab_q=0; next block must start with sob. Table contents survive reset.
- Write latency: value written in cycle t is read by any stream beat whose stage-1 read occurs at t+1 or later.

## Configuration

- FLOW_QTAB_ERR_EN defined: out_err pulses 1 cycle, aligned with the offending output beat, when (a) eob beat arrives with cnt≠64/N−1 (and not sob), or (b) sob beat arrives with cnt≠0. Framing still processed as in Operation.
- Undefined: checker not built; out_err tied 0.

## Structure

- Package flow_pkg: COEF_NUM=64, DATA_W=16, MULT_W=10, typedefs coef_t (signed [15:0]) and mult_t (unsigned [9:0]).
- Sub-module flow_qtab_ram: simple dual-port RAM, one write port with N lane enables, one registered read port with read enable; inference-friendly, no reset.

## Test plan

- Load table 0 with value k+1 at index k, N=2; stream one block (32 beats, sob on beat 0, eob on beat 31) → out_mult beat j = {2j+2, 2j+1} (lane1, lane0), data unchanged, latency 2.
- Table 1 loaded with 100+k; blocks with in_tab=1 then 0 back-to-back → first block multipliers 100+k, second k+1; in_tab changes mid-block ignored.
- Invalid gaps and en=0 for 3 cycles mid-block → multipliers still follow index order, no skipped/duplicated index, outputs frozen during en=0.
- Write index 5 of table 0 to 777 in same cycle its word is read → that beat sees old value 6; next block sees 777.
- With FLOW_QTAB_ERR_EN: eob on beat 20 → out_err=1 on that output beat only; next sob block reads from word 0 with out_err=0. Without macro → out_err stays 0.
- Assert rst at beat 10 → all outputs 0 within reset; after release new block starts at index 0 with previously loaded table values intact.

Source files
------------

// File: rtl/flow_qtab_pkg.sv
// flow_pkg: shared constants and element types for the JPEG flow pipeline
// quantization-table stage.
//   COEF_NUM : coefficients per 8x8 block
//   DATA_W   : coefficient width (signed)
//   MULT_W   : quantization multiplier width (unsigned)
//   tab_w()  : width of a table-select field, at least one bit
package flow_pkg;

  localparam int COEF_NUM = 64;
  localparam int DATA_W   = 16;
  localparam int MULT_W   = 10;

  typedef logic signed [DATA_W-1:0] coef_t;
  typedef logic        [MULT_W-1:0] mult_t;

  // Table-select width; a single table still gets a 1-bit field.
  function automatic int tab_w(input int q_num);
    return (q_num > 1) ? $clog2(q_num) : 1;
  endfunction

endpackage

// File: rtl/flow_qtab_ram.sv
// flow_qtab_ram: simple dual-port multiplier table.
// One write port with per-lane enables (one lane written per access) and one
// registered read port with read enable. No reset on storage or read data.
// A read and write of the same word on the same edge returns the old word.
//   clk        : clock
//   wr_en      : write strobe
//   wr_lane_en : lane enables within the addressed word
//   wr_addr    : write word address
//   wr_data    : multiplier value replicated to the enabled lane(s)
//   rd_en      : read enable; read data holds when low
//   rd_addr    : read word address
//   rd_data    : registered read word, N lanes of MULT_W bits
module flow_qtab_ram
  import flow_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [N-1:0]      wr_lane_en,
  input  logic [AW-1:0]     wr_addr,
  input  mult_t             wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [N*MULT_W-1:0] rd_data
);

  logic [N*MULT_W-1:0] mem [2**AW];

  // Lane-masked write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wr_en && wr_lane_en[i]) begin
        mem[wr_addr][i*MULT_W +: MULT_W] <= wr_data;
      end
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/flow_qtab.sv
// flow_qtab: quantization-table lookup stage ahead of the flow multiplier.
// Tracks each beat's position inside its 64-coefficient block and attaches
// the N matching 10-bit multipliers from a host-loadable table.
// Latency is two enabled cycles; en=0 freezes the pipeline and beat counter.
// Optional framing checker: define FLOW_QTAB_ERR_EN to build it; otherwise
// out_err is tied low.
//   clk, rst                 : clock, asynchronous active-high reset
//   en                       : pipeline enable
//   wr_en/wr_tab/wr_addr/wr_data : table write port (independent of en)
//   in_valid/in_data/in_tab  : input beat, table select sampled on sob
//   in_eob/in_sob/in_sof     : input framing
//   out_valid/out_data/out_mult : output beat with per-lane multipliers
//   out_eob/out_sob/out_sof  : delayed framing
//   out_err                  : framing error pulse aligned with its beat
module flow_qtab
  import flow_pkg::*;
#(
  parameter int N     = 2,
  parameter int Q_NUM = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [tab_w(Q_NUM)-1:0] wr_tab,
  input  logic [5:0]              wr_addr,
  input  mult_t                   wr_data,
  input  logic                    in_valid,
  input  logic signed [N*DATA_W-1:0] in_data,
  input  logic [tab_w(Q_NUM)-1:0] in_tab,
  input  logic                    in_eob,
  input  logic                    in_sob,
  input  logic                    in_sof,
  output logic                    out_valid,
  output logic signed [N*DATA_W-1:0] out_data,
  output logic [N*MULT_W-1:0]     out_mult,
  output logic                    out_eob,
  output logic                    out_sob,
  output logic                    out_sof,
  output logic                    out_err
);

  localparam int TW    = tab_w(Q_NUM);
  localparam int WORDS = COEF_NUM / N;
  localparam int LG    = $clog2(N);
  localparam int CW    = $clog2(WORDS);   // equals 6 - LG
  localparam int AW    = TW + CW;

  logic [CW-1:0] cnt_r;
  logic [TW-1:0] tab_r;

  logic [CW-1:0] rd_word_s;
  logic [TW-1:0] rd_tab_s;
  logic [N-1:0]  wr_lane_en_s;
  logic [N*MULT_W-1:0] ram_rd_s;

  logic              s1_valid_r;
  logic              s1_sob_r;
  logic              s1_eob_r;
  logic              s1_sof_r;
  logic signed [N*DATA_W-1:0] s1_data_r;

  // Read address: sob restarts at word 0 with the freshly selected table.
  always_comb begin
    rd_word_s = cnt_r;
    rd_tab_s  = tab_r;
    if (in_sob) begin
      rd_word_s = '0;
      rd_tab_s  = in_tab;
    end else begin
      rd_word_s = cnt_r;
      rd_tab_s  = tab_r;
    end
  end

  // Lane select of the write: coefficient index modulo N.
  always_comb begin
    wr_lane_en_s = '0;
    for (int i = 0; i < N; i++) begin
      wr_lane_en_s[i] = ((wr_addr & 6'(N - 1)) == 6'(i));
    end
  end

  flow_qtab_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_lane_en (wr_lane_en_s),
    .wr_addr    ({wr_tab, wr_addr[5:LG]}),
    .wr_data    (wr_data),
    .rd_en      (en),
    .rd_addr    ({rd_tab_s, rd_word_s}),
    .rd_data    (ram_rd_s)
  );

  // Beat counter and block table; eob overrides the increment (and sob).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      tab_r <= '0;
    end else if (en && in_valid) begin
      if (in_sob) begin
        tab_r <= in_tab;
      end
      if (in_eob) begin
        cnt_r <= '0;
      end else if (in_sob) begin
        cnt_r <= CW'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Two-stage stream pipeline; stage 2 takes the RAM read register as mult.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sob_r   <= 1'b0;
      s1_eob_r   <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_data_r  <= '0;
      out_valid  <= 1'b0;
      out_sob    <= 1'b0;
      out_eob    <= 1'b0;
      out_sof    <= 1'b0;
      out_data   <= '0;
      out_mult   <= '0;
    end else if (en) begin
      // Framing is qualified by valid so idle beats carry no markers.
      s1_valid_r <= in_valid;
      s1_sob_r   <= in_valid & in_sob;
      s1_eob_r   <= in_valid & in_eob;
      s1_sof_r   <= in_valid & in_sof;
      s1_data_r  <= in_data;
      out_valid  <= s1_valid_r;
      out_sob    <= s1_sob_r;
      out_eob    <= s1_eob_r;
      out_sof    <= s1_sof_r;
      out_data   <= s1_data_r;
      out_mult   <= ram_rd_s;
    end
  end

`ifdef FLOW_QTAB_ERR_EN
  logic err_s;
  logic s1_err_r;

  // Framing check: eob must land on the last word, sob on a fresh block.
  always_comb begin
    err_s = 1'b0;
    if (in_valid) begin
      err_s = (in_sob && (cnt_r != '0)) ||
              (in_eob && !in_sob && (cnt_r != CW'(WORDS - 1)));
    end else begin
      err_s = 1'b0;
    end
  end

  // Error flag travels with its beat through both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_err_r <= 1'b0;
      out_err  <= 1'b0;
    end else if (en) begin
      s1_err_r <= err_s;
      out_err  <= s1_err_r;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
